// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger access arbiter: opcodes, FSM states
// and the fixed index widths used on the terminal bus.
package atm_pkg;

  localparam logic [1:0] OP_BALANCE  = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_TRANSFER = 2'b11;

  localparam int INIT_BAL_DEFAULT = 500;
  localparam int ACC_IDX_W        = 4;
  localparam int TERM_ID_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_READ,
    ST_CHECK,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ledger_access_arbiter_if.sv
// Terminal-side bus of the ledger arbiter: packed per-terminal request fields
// plus the shared grant/response signals.
interface ledger_access_arbiter_if #(
  parameter int NUM_TERM = 2,
  parameter int AMT_W    = 11,
  parameter int BAL_W    = 16
);
  import atm_pkg::*;

  logic [NUM_TERM-1:0]           req;
  logic [2*NUM_TERM-1:0]         op;
  logic [ACC_IDX_W*NUM_TERM-1:0] src_idx;
  logic [ACC_IDX_W*NUM_TERM-1:0] dst_idx;
  logic [AMT_W*NUM_TERM-1:0]     amount;
  logic [NUM_TERM-1:0]           grant;
  logic                          busy;
  logic                          resp_valid;
  logic [TERM_ID_W-1:0]          resp_term;
  logic                          resp_error;
  logic [BAL_W-1:0]              resp_balance;

  modport master (
    output req, op, src_idx, dst_idx, amount,
    input  grant, busy, resp_valid, resp_term, resp_error, resp_balance
  );

  modport slave (
    input  req, op, src_idx, dst_idx, amount,
    output grant, busy, resp_valid, resp_term, resp_error, resp_balance
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: the terminal after the last one served gets first
// look, wrapping modulo NUM_TERM. The winner is purely combinational.
module rr_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_TERM = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_TERM-1:0]  req,
  input  logic                 ptr_upd,
  input  logic [TERM_ID_W-1:0] served_id,
  output logic [NUM_TERM-1:0]  win_onehot,
  output logic [TERM_ID_W-1:0] win_id
);

  logic [TERM_ID_W-1:0] last_q, last_d;
  logic                 found;
  int                   cand;

  // Remember who was served most recently.
  always_comb begin
    last_d = last_q;
    if (ptr_upd) last_d = served_id;
  end

  // Reset to the top terminal so terminal 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) last_q <= TERM_ID_W'(NUM_TERM - 1);
    else     last_q <= last_d;
  end

  // Scan terminals starting just after the last served one.
  always_comb begin
    win_onehot = '0;
    win_id     = '0;
    found      = 1'b0;
    cand       = 0;
    for (int i = 1; i <= NUM_TERM; i++) begin
      cand = (int'(last_q) + i) % NUM_TERM;
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_id           = TERM_ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ledger_access_arbiter.sv
// Owns the account ledger and serialises terminal requests through a fixed
// read-check-write sequence so no two terminals can race on an account.
module ledger_access_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_TERM = 2,
  parameter int NUM_ACC  = 10,
  parameter int BAL_W    = 16,
  parameter int AMT_W    = 11,
  parameter int INIT_BAL = INIT_BAL_DEFAULT
) (
  input logic clk,
  input logic rst,
  ledger_access_arbiter_if.slave bus
);

  state_t state_q, state_d;

  logic [NUM_TERM-1:0]  win_onehot_q, win_onehot_d;
  logic [TERM_ID_W-1:0] win_id_q, win_id_d;
  logic [1:0]           op_q, op_d;
  logic [ACC_IDX_W-1:0] src_q, src_d;
  logic [ACC_IDX_W-1:0] dst_q, dst_d;
  logic [AMT_W-1:0]     amt_q, amt_d;
  logic [BAL_W-1:0]     src_bal_q, src_bal_d;
  logic [BAL_W-1:0]     dst_bal_q, dst_bal_d;
  logic                 err_q, err_d;
  logic [BAL_W-1:0]     new_src_q, new_src_d;
  logic [BAL_W-1:0]     new_dst_q, new_dst_d;
  logic [BAL_W-1:0]     ledger_q [NUM_ACC];
  logic [BAL_W-1:0]     ledger_d [NUM_ACC];
  logic [TERM_ID_W-1:0] resp_term_q, resp_term_d;
  logic                 resp_error_q, resp_error_d;
  logic [BAL_W-1:0]     resp_balance_q, resp_balance_d;

  logic [NUM_TERM-1:0]  arb_onehot;
  logic [TERM_ID_W-1:0] arb_id;
  logic                 ptr_upd;

  logic [BAL_W:0]   amt_ext, sum_src, sum_dst;
  logic [BAL_W-1:0] diff_src;
  logic             src_oob, dst_oob, is_xfer, is_debit;
  logic             chk_err;
  logic [BAL_W-1:0] chk_new_src;

  rr_arbiter #(.NUM_TERM(NUM_TERM)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.req),
    .ptr_upd    (ptr_upd),
    .served_id  (arb_id),
    .win_onehot (arb_onehot),
    .win_id     (arb_id)
  );

  // Rule checks and candidate balances, one bit wider to expose overflow.
  always_comb begin
    amt_ext   = (BAL_W+1)'(amt_q);
    sum_src   = {1'b0, src_bal_q} + amt_ext;
    sum_dst   = {1'b0, dst_bal_q} + amt_ext;
    diff_src  = src_bal_q - BAL_W'(amt_q);
    src_oob   = int'(src_q) >= NUM_ACC;
    dst_oob   = int'(dst_q) >= NUM_ACC;
    is_xfer   = (op_q == OP_TRANSFER);
    is_debit  = (op_q == OP_WITHDRAW) || is_xfer;
    chk_err   = src_oob
             || (is_xfer && (dst_oob || (dst_q == src_q)))
             || (is_debit && (amt_ext > {1'b0, src_bal_q}))
             || ((op_q == OP_DEPOSIT) && sum_src[BAL_W])
             || (is_xfer && sum_dst[BAL_W]);
    chk_new_src = src_bal_q;
    if (is_debit)                 chk_new_src = diff_src;
    else if (op_q == OP_DEPOSIT)  chk_new_src = sum_src[BAL_W-1:0];
  end

  // Next-state and datapath sequencing for one request at a time.
  always_comb begin
    state_d        = state_q;
    win_onehot_d   = win_onehot_q;
    win_id_d       = win_id_q;
    op_d           = op_q;
    src_d          = src_q;
    dst_d          = dst_q;
    amt_d          = amt_q;
    src_bal_d      = src_bal_q;
    dst_bal_d      = dst_bal_q;
    err_d          = err_q;
    new_src_d      = new_src_q;
    new_dst_d      = new_dst_q;
    ledger_d       = ledger_q;
    resp_term_d    = resp_term_q;
    resp_error_d   = resp_error_q;
    resp_balance_d = resp_balance_q;
    ptr_upd        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d      = ST_LATCH;
          ptr_upd      = 1'b1;
          win_onehot_d = arb_onehot;
          win_id_d     = arb_id;
          op_d         = bus.op[int'(arb_id)*2 +: 2];
          src_d        = bus.src_idx[int'(arb_id)*ACC_IDX_W +: ACC_IDX_W];
          dst_d        = bus.dst_idx[int'(arb_id)*ACC_IDX_W +: ACC_IDX_W];
          amt_d        = bus.amount[int'(arb_id)*AMT_W +: AMT_W];
        end
      end
      ST_LATCH: state_d = ST_READ;
      ST_READ: begin
        src_bal_d = '0;
        dst_bal_d = '0;
        for (int a = 0; a < NUM_ACC; a++) begin
          if (int'(src_q) == a) src_bal_d = ledger_q[a];
          if (int'(dst_q) == a) dst_bal_d = ledger_q[a];
        end
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_d     = chk_err;
        new_src_d = chk_err ? src_bal_q : chk_new_src;
        new_dst_d = sum_dst[BAL_W-1:0];
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (!err_q && (op_q != OP_BALANCE)) begin
          for (int a = 0; a < NUM_ACC; a++) begin
            if (int'(src_q) == a) ledger_d[a] = new_src_q;
            if (is_xfer && (int'(dst_q) == a)) ledger_d[a] = new_dst_q;
          end
        end
        resp_term_d    = win_id_q;
        resp_error_d   = err_q;
        resp_balance_d = new_src_q;
        state_d        = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ledger and response registers; reset reloads every account.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      win_onehot_q   <= '0;
      win_id_q       <= '0;
      op_q           <= OP_BALANCE;
      src_q          <= '0;
      dst_q          <= '0;
      amt_q          <= '0;
      src_bal_q      <= '0;
      dst_bal_q      <= '0;
      err_q          <= 1'b0;
      new_src_q      <= '0;
      new_dst_q      <= '0;
      for (int a = 0; a < NUM_ACC; a++) ledger_q[a] <= BAL_W'(INIT_BAL);
      resp_term_q    <= '0;
      resp_error_q   <= 1'b0;
      resp_balance_q <= '0;
    end else begin
      state_q        <= state_d;
      win_onehot_q   <= win_onehot_d;
      win_id_q       <= win_id_d;
      op_q           <= op_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      amt_q          <= amt_d;
      src_bal_q      <= src_bal_d;
      dst_bal_q      <= dst_bal_d;
      err_q          <= err_d;
      new_src_q      <= new_src_d;
      new_dst_q      <= new_dst_d;
      ledger_q       <= ledger_d;
      resp_term_q    <= resp_term_d;
      resp_error_q   <= resp_error_d;
      resp_balance_q <= resp_balance_d;
    end
  end

  assign bus.grant        = (state_q == ST_LATCH) ? win_onehot_q : '0;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.resp_valid   = (state_q == ST_RESP);
  assign bus.resp_term    = resp_term_q;
  assign bus.resp_error   = resp_error_q;
  assign bus.resp_balance = resp_balance_q;

endmodule

// File: tb/tb_ledger_access_arbiter.sv
// Directed bench for the ledger arbiter with two terminals and default sizes.
module tb_ledger_access_arbiter;
  import atm_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  ledger_access_arbiter_if #(.NUM_TERM(2), .AMT_W(11), .BAL_W(16)) bus();

  ledger_access_arbiter #(
    .NUM_TERM(2), .NUM_ACC(10), .BAL_W(16), .AMT_W(11), .INIT_BAL(500)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and a cycle counter for latency measurements.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic do_op(input int t, input logic [1:0] o, input logic [3:0] s,
                       input logic [3:0] d, input logic [10:0] a,
                       output int gd, output int rd, output logic e,
                       output logic [15:0] b, output logic [2:0] tm,
                       output logic [1:0] gv);
    int start;
    bit done;
    @(negedge clk);
    bus.op[t*2 +: 2]      = o;
    bus.src_idx[t*4 +: 4] = s;
    bus.dst_idx[t*4 +: 4] = d;
    bus.amount[t*11 +: 11] = a;
    bus.req[t] = 1'b1;
    start = cyc;
    gd = -1; rd = -1; e = 1'b0; b = '0; tm = '0; gv = '0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.grant != 2'b00 && gd < 0) begin gd = cyc - start; gv = bus.grant; end
      if (bus.resp_valid && bus.resp_term == 3'(t)) begin
        rd = cyc - start; e = bus.resp_error; b = bus.resp_balance; tm = bus.resp_term;
        done = 1'b1;
      end
    end
    bus.req[t] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.src_idx = '0; bus.dst_idx = '0; bus.amount = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant !== 2'b00) $display("[TB] FAIL reset_grant got %b expected 00", bus.grant); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %b expected 0", bus.resp_valid); else passes++;
    checks++; if (bus.resp_term !== 3'd0) $display("[TB] FAIL reset_resp_term got %0d expected 0", bus.resp_term); else passes++;
    checks++; if (bus.resp_error !== 1'b0) $display("[TB] FAIL reset_resp_error got %b expected 0", bus.resp_error); else passes++;
    checks++; if (bus.resp_balance !== 16'd0) $display("[TB] FAIL reset_resp_balance got %0d expected 0", bus.resp_balance); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_balance();
    int gd, rd; logic e; logic [15:0] b; logic [2:0] tm; logic [1:0] gv;
    do_op(0, OP_BALANCE, 4'd3, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (gd !== 1) $display("[TB] FAIL bal_grant_latency got %0d expected 1", gd); else passes++;
    checks++; if (rd !== 5) $display("[TB] FAIL bal_resp_latency got %0d expected 5", rd); else passes++;
    checks++; if (gv !== 2'b01) $display("[TB] FAIL bal_grant_vec got %b expected 01", gv); else passes++;
    checks++; if (tm !== 3'd0) $display("[TB] FAIL bal_resp_term got %0d expected 0", tm); else passes++;
    checks++; if (e !== 1'b0) $display("[TB] FAIL bal_resp_error got %b expected 0", e); else passes++;
    checks++; if (b !== 16'd500) $display("[TB] FAIL bal_resp_balance got %0d expected 500", b); else passes++;
  endtask

  task automatic test_withdraw();
    int gd, rd; logic e; logic [15:0] b; logic [2:0] tm; logic [1:0] gv;
    do_op(0, OP_WITHDRAW, 4'd2, 4'd0, 11'd200, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd300) $display("[TB] FAIL wd200 got err=%b bal=%0d expected err=0 bal=300", e, b); else passes++;
    do_op(0, OP_WITHDRAW, 4'd2, 4'd0, 11'd400, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd300) $display("[TB] FAIL wd400_overdraw got err=%b bal=%0d expected err=1 bal=300", e, b); else passes++;
    do_op(0, OP_BALANCE, 4'd2, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd300) $display("[TB] FAIL acct2_after got err=%b bal=%0d expected err=0 bal=300", e, b); else passes++;
    do_op(0, OP_WITHDRAW, 4'd6, 4'd0, 11'd500, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd0) $display("[TB] FAIL wd_exact got err=%b bal=%0d expected err=0 bal=0", e, b); else passes++;
    do_op(0, OP_WITHDRAW, 4'd0, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd500) $display("[TB] FAIL wd_zero got err=%b bal=%0d expected err=0 bal=500", e, b); else passes++;
  endtask

  task automatic test_transfer();
    int gd, rd; logic e; logic [15:0] b; logic [2:0] tm; logic [1:0] gv;
    do_op(1, OP_TRANSFER, 4'd4, 4'd7, 11'd150, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd350 || tm !== 3'd1) $display("[TB] FAIL xfer150 got err=%b bal=%0d term=%0d expected err=0 bal=350 term=1", e, b, tm); else passes++;
    checks++; if (gv !== 2'b10) $display("[TB] FAIL xfer_grant_vec got %b expected 10", gv); else passes++;
    do_op(1, OP_BALANCE, 4'd4, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (b !== 16'd350) $display("[TB] FAIL acct4_after_xfer got %0d expected 350", b); else passes++;
    do_op(1, OP_BALANCE, 4'd7, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (b !== 16'd650) $display("[TB] FAIL acct7_after_xfer got %0d expected 650", b); else passes++;
    do_op(1, OP_TRANSFER, 4'd4, 4'd4, 11'd10, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd350) $display("[TB] FAIL xfer_self got err=%b bal=%0d expected err=1 bal=350", e, b); else passes++;
    do_op(1, OP_BALANCE, 4'd4, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (b !== 16'd350) $display("[TB] FAIL acct4_after_self got %0d expected 350", b); else passes++;
    do_op(1, OP_TRANSFER, 4'd8, 4'd10, 11'd5, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd500) $display("[TB] FAIL xfer_bad_dst got err=%b bal=%0d expected err=1 bal=500", e, b); else passes++;
    do_op(1, OP_TRANSFER, 4'd2, 4'd7, 11'd301, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd300) $display("[TB] FAIL xfer_overdraw got err=%b bal=%0d expected err=1 bal=300", e, b); else passes++;
  endtask

  task automatic test_deposit();
    int gd, rd; logic e; logic [15:0] b; logic [2:0] tm; logic [1:0] gv;
    int nerr;
    nerr = 0;
    for (int i = 0; i < 31; i++) begin
      do_op(0, OP_DEPOSIT, 4'd1, 4'd0, 11'd2047, gd, rd, e, b, tm, gv);
      if (e !== 1'b0) nerr++;
    end
    checks++; if (nerr !== 0) $display("[TB] FAIL dep_fill_errors got %0d expected 0", nerr); else passes++;
    checks++; if (b !== 16'd63957) $display("[TB] FAIL dep_fill_balance got %0d expected 63957", b); else passes++;
    do_op(0, OP_DEPOSIT, 4'd1, 4'd0, 11'd2047, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd63957) $display("[TB] FAIL dep_overflow got err=%b bal=%0d expected err=1 bal=63957", e, b); else passes++;
    do_op(1, OP_TRANSFER, 4'd7, 4'd1, 11'd2047, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd650) $display("[TB] FAIL xfer_dst_overflow got err=%b bal=%0d expected err=1 bal=650", e, b); else passes++;
    do_op(1, OP_BALANCE, 4'd12, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b1 || b !== 16'd0) $display("[TB] FAIL bad_src got err=%b bal=%0d expected err=1 bal=0", e, b); else passes++;
  endtask

  task automatic test_back_to_back();
    int g_who [4];
    int g_cyc [4];
    int r_cyc [4];
    int r_term [4];
    int r_bal [4];
    int ng, nr;
    bit changed;
    int exp_who [4];
    int exp_bal [4];
    exp_who = '{0, 1, 0, 1};
    exp_bal = '{510, 510, 1510, 1510};
    ng = 0; nr = 0; changed = 1'b0;
    for (int i = 0; i < 4; i++) begin g_who[i] = -1; g_cyc[i] = 0; r_cyc[i] = 0; r_term[i] = -1; r_bal[i] = -1; end
    @(negedge clk);
    bus.op[1:0] = OP_DEPOSIT; bus.src_idx[3:0] = 4'd0; bus.amount[10:0] = 11'd10;
    bus.op[3:2] = OP_BALANCE; bus.src_idx[7:4] = 4'd0; bus.amount[21:11] = 11'd0;
    bus.req = 2'b11;
    for (int k = 0; k < 40 && nr < 4; k++) begin
      @(negedge clk);
      if (!changed && ng >= 1 && cyc == g_cyc[0] + 1) begin
        bus.amount[10:0] = 11'd1000;
        changed = 1'b1;
      end
      if (bus.grant != 2'b00 && ng < 4) begin
        g_who[ng] = (bus.grant == 2'b01) ? 0 : (bus.grant == 2'b10) ? 1 : 9;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (bus.resp_valid && nr < 4) begin
        r_term[nr] = int'(bus.resp_term);
        r_bal[nr]  = int'(bus.resp_balance);
        r_cyc[nr]  = cyc;
        nr++;
      end
    end
    bus.req = 2'b00;
    checks++; if (nr !== 4) $display("[TB] FAIL b2b_resp_count got %0d expected 4", nr); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_who[i] !== exp_who[i]) $display("[TB] FAIL b2b_grant%0d got %0d expected %0d", i, g_who[i], exp_who[i]); else passes++;
      checks++; if (r_term[i] !== exp_who[i]) $display("[TB] FAIL b2b_term%0d got %0d expected %0d", i, r_term[i], exp_who[i]); else passes++;
      checks++; if (r_bal[i] !== exp_bal[i]) $display("[TB] FAIL b2b_bal%0d got %0d expected %0d", i, r_bal[i], exp_bal[i]); else passes++;
      checks++; if (r_cyc[i] - g_cyc[i] !== 4) $display("[TB] FAIL b2b_lat%0d got %0d expected 4", i, r_cyc[i] - g_cyc[i]); else passes++;
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (r_cyc[i] - r_cyc[i-1] !== 6) $display("[TB] FAIL b2b_spacing%0d got %0d expected 6", i, r_cyc[i] - r_cyc[i-1]); else passes++;
    end
  endtask

  task automatic test_reset_midop();
    int gd, rd; logic e; logic [15:0] b; logic [2:0] tm; logic [1:0] gv;
    bit saw_resp;
    @(negedge clk);
    bus.op[1:0] = OP_WITHDRAW; bus.src_idx[3:0] = 4'd5; bus.amount[10:0] = 11'd100;
    bus.req[0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL midop_busy got %b expected 1", bus.busy); else passes++;
    rst = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) $display("[TB] FAIL midop_resp_valid got %b expected 0", bus.resp_valid); else passes++;
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) $display("[TB] FAIL midop_grant_busy got %b/%b expected 00/0", bus.grant, bus.busy); else passes++;
    checks++; if (bus.resp_term !== 3'd0 || bus.resp_error !== 1'b0 || bus.resp_balance !== 16'd0)
      $display("[TB] FAIL midop_resp_regs got term=%0d err=%b bal=%0d expected 0/0/0", bus.resp_term, bus.resp_error, bus.resp_balance); else passes++;
    rst = 1'b0;
    saw_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    checks++; if (saw_resp !== 1'b0) $display("[TB] FAIL midop_late_resp got %b expected 0", saw_resp); else passes++;
    do_op(0, OP_BALANCE, 4'd5, 4'd0, 11'd0, gd, rd, e, b, tm, gv);
    checks++; if (e !== 1'b0 || b !== 16'd500) $display("[TB] FAIL midop_acct5 got err=%b bal=%0d expected err=0 bal=500", e, b); else passes++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    cyc = 0;
    checks = 0;
    passes = 0;
    test_reset();
    test_balance();
    test_withdraw();
    test_transfer();
    test_deposit();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ledger_access_arbiter.md
Name: ledger_access_arbiter

Overview:
Shares the single account balance ledger between NUM_TERM ATM terminal front-ends. Accepts balance, withdraw, deposit and transfer requests, grants one terminal at a time in round-robin order, and sequences each request as a fixed-latency read-check-write. It owns the ledger register file, so every balance update goes through this block and no two terminals can race on an account.

Parameters:
NUM_TERM, 2, number of requesting terminals (2..8)
NUM_ACC, 10, number of ledger accounts (indices 0..NUM_ACC-1)
BAL_W, 16, balance width
AMT_W, 11, request amount width
INIT_BAL, 500, per-account balance loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_TERM  per-terminal request, level
op  in  2*NUM_TERM  per-terminal opcode: 00 balance, 01 withdraw, 10 deposit, 11 transfer
src_idx  in  4*NUM_TERM  per-terminal source account index
dst_idx  in  4*NUM_TERM  per-terminal destination index (transfer only)
amount  in  AMT_W*NUM_TERM  per-terminal amount, unsigned
grant  out  NUM_TERM  one-hot, high for the single cycle the request is latched
busy  out  1  high from grant through resp_valid inclusive
resp_valid  out  1  one-cycle completion pulse
resp_term  out  3  terminal id of the completed request
resp_error  out  1  request rejected; ledger unchanged
resp_balance  out  BAL_W  source balance after the op (unchanged on error)

Behaviour:
- Reset (synchronous, active-high): state IDLE; grant=0, busy=0, resp_valid=0, resp_term=0, resp_error=0, resp_balance=0; every ledger entry = INIT_BAL; RR pointer set so terminal 0 has highest priority. Reset mid-operation abandons the in-flight op with no ledger write and no response.
- FSM: IDLE -> LATCH -> READ -> CHECK -> WRITE -> RESP -> IDLE.
- IDLE: when any req is high, select the winner and go to LATCH. With no req, stay in IDLE.
- LATCH: assert grant[winner]. Capture op, src, dst and amount into internal registers. Later input changes do not affect this op.
- READ: fetch ledger[src] and, for transfer, ledger[dst].
- CHECK: evaluate the error conditions below and compute new values at BAL_W+1 bits.
- WRITE: commit only if no error. For transfer, both entries commit in the same cycle.
- RESP: assert resp_valid, resp_term, resp_error and resp_balance for one cycle. Outputs hold until the next RESP.
- Latency: req sampled high in IDLE at cycle N gives grant at N+1 and resp_valid at N+5. Back-to-back throughput is one op per 6 cycles.
- Handshake: a terminal holds req until it sees resp_valid with resp_term equal to its id, then drops req the next cycle. A req still high in IDLE after RESP counts as a new request.
- Round-robin: after serving terminal k, the priority order is k+1, k+2, ... modulo NUM_TERM. A lone requester is served repeatedly.
- Error conditions:
  - src_idx >= NUM_ACC.
  - Transfer with dst_idx >= NUM_ACC.
  - Transfer with dst_idx == src_idx.
  - Withdraw or transfer with amount > ledger[src].
  - Deposit with ledger[src]+amount > 2^BAL_W-1.
  - Transfer with ledger[dst]+amount > 2^BAL_W-1.
- Balance op: never writes. It errors only on a bad src_idx.
- amount=0 is legal for every op and leaves the ledger unchanged.
- resp_balance on error: the current ledger[src], or 0 if src_idx is out of range.
- Requests arriving while busy wait. There is no queueing beyond the level req.

Decomposition:
- atm_pkg holds:
  - opcode constants OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_TRANSFER;
  - the FSM state enum;
  - INIT_BAL_DEFAULT, ACC_IDX_W = 4, TERM_ID_W = 3.
- One sub-module, rr_arbiter (NUM_TERM param): takes req vector, pointer update enable and last-served id; returns one-hot winner and winner id combinationally.
- The ledger register file, checks and FSM stay in the top block.

Test Plan:
- Reset, terminal 0 balance op on src 3 -> grant[0] at N+1, resp_valid at N+5, resp_term=0, resp_error=0, resp_balance=500.
- T0 withdraw 200 from acct 2, then T0 withdraw 400 from acct 2 -> first resp_balance=300, error=0; second error=1, resp_balance=300, ledger[2] stays 300.
- T1 transfer 150 from acct 4 to acct 7, then balance ops on 4 and 7 -> 350 and 650. Transfer 4->4 -> error=1, no change.
- Deposit 2047 to acct 1 repeatedly -> reaches 500+31*2047=63957. The next deposit of 2047 errors (65535 limit), balance stays 63957. Also check src_idx=12 -> error=1, resp_balance=0.
- T0 and T1 hold req continuously -> grants alternate 0,1,0,1, each resp 6 cycles apart. Changing T0's amount after its grant does not alter that op's result.
- Assert rst during WRITE of a withdraw 100 on acct 5 -> no resp_valid; all outputs 0 next cycle; ledger[5]=500 afterward.
